// File: rtl/sig_gen_pkg.sv
// Shared constants and helpers for the multi-channel signal generator:
// register addresses, reset values, LFSR seed/taps and the reset period formula.
package sig_gen_pkg;

    localparam logic [4:0]  ADDR_TONE_EN    = 5'h10;
    localparam logic [4:0]  ADDR_NOISE_VOL  = 5'h11;
    localparam logic [4:0]  ADDR_NOISE_CTRL = 5'h12;
    localparam logic [4:0]  ADDR_ENV_EN     = 5'h13;

    localparam logic [15:0] LFSR_SEED       = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS       = 16'h002D;

    localparam logic [3:0]  RST_VOLUME      = 4'd8;
    localparam logic [3:0]  RST_NOISE_VOL   = 4'd3;

    function automatic logic [11:0] reset_period(input int ch);
        return 12'(32'd200 + 32'd100 * ch);
    endfunction

    function automatic logic parity16(input logic [15:0] v);
        return ^v;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {parity16(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: staged period writes (shadow/pending/active),
// half-period counter with glitch-free period switching, and a decaying volume level.
module tone_channel
    import sig_gen_pkg::*;
#(
    parameter int CH_IDX   = 0,
    parameter int PERIOD_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_data,
    input  logic       enable,
    input  logic       env_en,
    input  logic       env_pulse,
    output logic       wave,
    output logic [3:0] level
);

    localparam logic [11:0]         RST_FULL   = reset_period(CH_IDX);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = RST_FULL[PERIOD_W-1:0];

    logic [11:0]         shadow_r;
    logic [11:0]         commit_s;
    logic [PERIOD_W-1:0] pending_r;
    logic [PERIOD_W-1:0] active_r;
    logic [PERIOD_W-1:0] counter_r;
    logic                pend_valid_r;
    logic                wave_r;
    logic [3:0]          vol_r;
    logic [3:0]          level_r;
    logic                wrap_s;
    logic                load_s;

    // Wrap detection and pending-period hand-over condition
    always_comb begin
        commit_s = {wr_data, shadow_r[7:0]};
        if (enable && (active_r != '0)) begin
            wrap_s = (counter_r >= (active_r - PERIOD_W'(1)));
        end else begin
            wrap_s = 1'b0;
        end
        load_s = pend_valid_r && (wrap_s || (active_r == '0));
    end

    // Period staging, half-period counter and wave; a write landing on a wrap
    // re-arms pending after the older pending value has been consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r     <= RST_FULL;
            pending_r    <= RST_PERIOD;
            active_r     <= RST_PERIOD;
            counter_r    <= '0;
            pend_valid_r <= 1'b0;
            wave_r       <= 1'b0;
        end else begin
            if (load_s) begin
                active_r     <= pending_r;
                pend_valid_r <= 1'b0;
            end
            if (!enable) begin
                wave_r <= 1'b0;
            end else if (active_r == '0) begin
                wave_r    <= 1'b0;
                counter_r <= '0;
            end else if (wrap_s) begin
                wave_r    <= ~wave_r;
                counter_r <= '0;
            end else begin
                counter_r <= counter_r + PERIOD_W'(1);
            end
            if (wr_en) begin
                case (wr_sel)
                    2'd0: shadow_r[3:0] <= wr_data;
                    2'd1: shadow_r[7:4] <= wr_data;
                    2'd2: begin
                        shadow_r[11:8] <= wr_data;
                        pending_r      <= commit_s[PERIOD_W-1:0];
                        pend_valid_r   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Volume register and envelope level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_r   <= RST_VOLUME;
            level_r <= RST_VOLUME;
        end else if (wr_en && (wr_sel == 2'd3)) begin
            vol_r   <= wr_data;
            level_r <= wr_data;
        end else if (!env_en) begin
            level_r <= vol_r;
        end else if (env_pulse && (level_r != 4'd0)) begin
            level_r <= level_r - 4'd1;
        end
    end

    assign wave  = wave_r;
    assign level = level_r;

endmodule

// File: rtl/multi_channel_signal_generator.sv
// N_CH tone channels plus an LFSR noise channel, mixed with saturation and
// played out through a free-running PWM.
module multi_channel_signal_generator
    import sig_gen_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int PERIOD_W  = 12,
    parameter int PWM_W     = 8,
    parameter int MIX_SHIFT = 2,
    parameter int ENV_DIV   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_strobe,
    input  logic [4:0] address,
    input  logic [3:0] data,
    output logic       signal_out,
    output logic [7:0] debug
);

    localparam int ENV_W = $clog2(ENV_DIV + 1);
    localparam int SUM_W = PWM_W + MIX_SHIFT + 8;
    localparam logic [SUM_W-1:0] MIX_MAX = SUM_W'((64'd1 << PWM_W) - 64'd1);

    logic [N_CH-1:0]  tone_en_r;
    logic [N_CH-1:0]  env_en_r;
    logic [3:0]       noise_vol_r;
    logic             noise_en_r;
    logic [2:0]       noise_rate_r;
    logic [ENV_W-1:0] env_cnt_r;
    logic             env_pulse_s;
    logic [6:0]       noise_cnt_r;
    logic             noise_step_s;
    logic [15:0]      lfsr_r;
    logic [N_CH-1:0]  wave_s;
    logic [3:0]       ch_level_s [N_CH];
    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] shifted_s;
    logic [PWM_W-1:0] mix_next_s;
    logic [PWM_W-1:0] mix_r;
    logic [PWM_W-1:0] pwm_cnt_r;
    logic [PWM_W-1:0] duty_r;
    logic             signal_out_r;
    logic [7:0]       debug_s;
    logic [7:0]       debug_r;

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        logic ch_wr_s;
        assign ch_wr_s = write_strobe && (address[4] == 1'b0) && (address[3:2] == 2'(i));
        tone_channel #(.CH_IDX(i), .PERIOD_W(PERIOD_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (ch_wr_s),
            .wr_sel   (address[1:0]),
            .wr_data  (data),
            .enable   (tone_en_r[i]),
            .env_en   (env_en_r[i]),
            .env_pulse(env_pulse_s),
            .wave     (wave_s[i]),
            .level    (ch_level_s[i])
        );
    end

    // Global control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_en_r    <= '1;
            env_en_r     <= '0;
            noise_vol_r  <= RST_NOISE_VOL;
            noise_en_r   <= 1'b1;
            noise_rate_r <= 3'd0;
        end else if (write_strobe) begin
            case (address)
                ADDR_TONE_EN:    tone_en_r <= data[N_CH-1:0];
                ADDR_NOISE_VOL:  noise_vol_r <= data;
                ADDR_NOISE_CTRL: begin
                    noise_en_r   <= data[3];
                    noise_rate_r <= data[2:0];
                end
                ADDR_ENV_EN:     env_en_r <= data[N_CH-1:0];
                default: ;
            endcase
        end
    end

    assign env_pulse_s  = (env_cnt_r == ENV_W'(ENV_DIV - 1));
    assign noise_step_s = noise_en_r && (noise_cnt_r >= {noise_rate_r, 4'hF});

    // Shared envelope prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_cnt_r <= '0;
        end else if (env_pulse_s) begin
            env_cnt_r <= '0;
        end else begin
            env_cnt_r <= env_cnt_r + ENV_W'(1);
        end
    end

    // Noise step timer and LFSR; a zero state is repaired by reseeding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_cnt_r <= 7'd0;
            lfsr_r      <= LFSR_SEED;
        end else begin
            if (noise_step_s) begin
                noise_cnt_r <= 7'd0;
            end else if (noise_en_r) begin
                noise_cnt_r <= noise_cnt_r + 7'd1;
            end
            if (lfsr_r == 16'h0000) begin
                lfsr_r <= LFSR_SEED;
            end else if (noise_step_s) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end
        end
    end

    // Mixer sum, shift and saturation
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (tone_en_r[i] && wave_s[i]) begin
                sum_s = sum_s + SUM_W'(ch_level_s[i]);
            end else begin
                sum_s = sum_s;
            end
        end
        if (noise_en_r && lfsr_r[0]) begin
            sum_s = sum_s + SUM_W'(noise_vol_r);
        end else begin
            sum_s = sum_s;
        end
        shifted_s = sum_s << MIX_SHIFT;
        if (shifted_s > MIX_MAX) begin
            mix_next_s = '1;
        end else begin
            mix_next_s = shifted_s[PWM_W-1:0];
        end
        debug_s = 8'h00;
        debug_s[N_CH-1:0] = wave_s;
        debug_s[N_CH] = lfsr_r[0];
    end

    // Mix register, PWM counter with wrap-latched duty, and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_r        <= '0;
            pwm_cnt_r    <= '0;
            duty_r       <= '0;
            signal_out_r <= 1'b0;
            debug_r      <= 8'h00;
        end else begin
            mix_r        <= mix_next_s;
            pwm_cnt_r    <= pwm_cnt_r + PWM_W'(1);
            if (pwm_cnt_r == '1) begin
                duty_r <= mix_r;
            end
            signal_out_r <= (pwm_cnt_r < duty_r);
            debug_r      <= debug_s;
        end
    end

    assign signal_out = signal_out_r;
    assign debug      = debug_r;

endmodule

// File: tb/tb_multi_channel_signal_generator.sv
// Directed self-checking bench for multi_channel_signal_generator; a second
// instance with MIX_SHIFT=3 exercises mixer saturation.
module tb_multi_channel_signal_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_strobe = 1'b0;
    logic [4:0] address = 5'd0;
    logic [3:0] data = 4'd0;
    logic       signal_out;
    logic [7:0] debug;
    logic       sat_signal_out;
    logic [7:0] sat_debug;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Cycle stamp used to time wave toggles
    always @(posedge clk) cyc <= cyc + 1;

    multi_channel_signal_generator dut (
        .clk(clk), .rst_n(rst_n), .write_strobe(write_strobe), .address(address),
        .data(data), .signal_out(signal_out), .debug(debug)
    );

    multi_channel_signal_generator #(.MIX_SHIFT(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .write_strobe(write_strobe), .address(address),
        .data(data), .signal_out(sat_signal_out), .debug(sat_debug)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] d);
        @(negedge clk);
        write_strobe = 1'b1;
        address = a;
        data = d;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_toggle(input int idx, output int t);
        logic prev;
        bit   found;
        int   n;
        prev = debug[idx];
        found = 1'b0;
        n = 0;
        t = 0;
        while (!found && n < 6000) begin
            @(negedge clk);
            n++;
            if (debug[idx] !== prev) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) check_eq("toggle_timeout", 32'd0, 32'd1);
    endtask

    // Length of one PWM high phase, counted over the 256 clocks of its period
    task automatic measure_run(output int n, output int n_sat);
        logic prev;
        bit   found;
        int   k;
        n = 0;
        n_sat = 0;
        prev = signal_out;
        found = 1'b0;
        k = 0;
        while (!found && k < 2000) begin
            @(negedge clk);
            k++;
            if (prev == 1'b0 && signal_out == 1'b1) found = 1'b1;
            prev = signal_out;
        end
        if (!found) begin
            check_eq("run_timeout", 32'd0, 32'd1);
        end else begin
            for (int i = 0; i < 256; i++) begin
                n += int'(signal_out);
                n_sat += int'(sat_signal_out);
                if (i < 255) @(negedge clk);
            end
        end
    endtask

    initial begin
        int t0, t1, t2, t3, run, run_sat, seen_hi, wt;
        logic [15:0] model;
        logic fb;

        // Reset values and noise sequence from the seed
        repeat (3) @(negedge clk);
        check_eq("rst_sig", 32'(signal_out), 32'd0);
        check_eq("rst_debug", 32'(debug), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_debug", 32'(debug), 32'h04);
        repeat (7) @(negedge clk);
        model = 16'hACE1;
        for (int k = 0; k < 40; k++) begin
            check_eq("lfsr_bit", 32'(debug[2]), 32'(model[0]));
            fb = model[0] ^ model[2] ^ model[3] ^ model[5];
            model = {fb, model[15:1]};
            repeat (16) @(negedge clk);
        end

        // Only ch0 playing: 200-clock half periods, duty 8<<2 while high
        wr(5'h10, 4'h1);
        wr(5'h12, 4'h0);
        wait_toggle(0, t0);
        wait_toggle(0, t1);
        wait_toggle(0, t2);
        check_eq("half_period_a", 32'(t1 - t0), 32'd200);
        check_eq("half_period_b", 32'(t2 - t1), 32'd200);
        check_eq("ch1_disabled", 32'(debug[1]), 32'd0);
        for (int k = 0; k < 2; k++) begin
            measure_run(run, run_sat);
            check_eq("duty_vol8", 32'(run), 32'd32);
            check_eq("duty_vol8_shift3", 32'(run_sat), 32'd64);
        end

        // Period change mid half-period takes effect only at the wrap
        wait_toggle(0, t0);
        wr(5'h00, 4'h4);
        wr(5'h01, 4'h6);
        wr(5'h02, 4'h0);
        wait_toggle(0, t1);
        wait_toggle(0, t2);
        wait_toggle(0, t3);
        check_eq("staged_old", 32'(t1 - t0), 32'd200);
        check_eq("staged_new_a", 32'(t2 - t1), 32'd100);
        check_eq("staged_new_b", 32'(t3 - t2), 32'd100);

        // Asynchronous reset while the PWM output is high
        wt = 0;
        @(negedge clk);
        while (signal_out !== 1'b1 && wt < 3000) begin
            @(negedge clk);
            wt++;
        end
        check_eq("pwm_high_before_rst", 32'(signal_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_sig", 32'(signal_out), 32'd0);
        check_eq("async_rst_debug", 32'(debug), 32'd0);
        check_eq("async_rst_sat_sig", 32'(sat_signal_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_toggle(0, t0);
        wait_toggle(1, t1);
        wait_toggle(0, t2);
        check_eq("rst_period_ch1_offset", 32'(t1 - t0), 32'd100);
        check_eq("rst_period_ch0", 32'(t2 - t0), 32'd200);

        // Full-volume mix, with and without noise, and saturation at shift 3
        do_reset();
        wr(5'h12, 4'h0);
        wr(5'h11, 4'hF);
        wr(5'h00, 4'hF); wr(5'h01, 4'hF); wr(5'h02, 4'hF);
        wr(5'h04, 4'hF); wr(5'h05, 4'hF); wr(5'h06, 4'hF);
        wr(5'h03, 4'hF);
        wr(5'h07, 4'hF);
        wt = 0;
        while (debug[1:0] !== 2'b11 && wt < 2000) begin
            @(negedge clk);
            wt++;
        end
        check_eq("both_tones_high", 32'(debug[1:0]), 32'd3);
        repeat (50) @(negedge clk);
        measure_run(run, run_sat);
        check_eq("mix_tones_only", 32'(run), 32'd120);
        check_eq("mix_tones_shift3", 32'(run_sat), 32'd240);
        wr(5'h12, 4'h8);
        seen_hi = 0;
        for (int k = 0; k < 8; k++) begin
            measure_run(run, run_sat);
            check_eq("mix_noise_level", 32'(run == 120 || run == 180), 32'd1);
            check_eq("mix_noise_sat", 32'(run_sat), (run == 180) ? 32'd255 : 32'd240);
            if (run == 180) seen_hi++;
        end
        check_eq("mix_noise_seen_high", 32'(seen_hi > 0), 32'd1);

        // Envelope decay on ch0, floor at 0, reload on volume write
        wr(5'h13, 4'h1);
        wr(5'h03, 4'h3);
        check_eq("env_start", 32'(dut.ch_level_s[0]), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            repeat (4096) @(negedge clk);
            check_eq("env_step", 32'(dut.ch_level_s[0]), (k >= 3) ? 32'd0 : 32'(3 - k));
        end
        wr(5'h03, 4'h3);
        check_eq("env_reload", 32'(dut.ch_level_s[0]), 32'd3);
        wr(5'h13, 4'h0);
        repeat (4100) @(negedge clk);
        check_eq("env_off_hold", 32'(dut.ch_level_s[0]), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
